gpio_port: RTL and testbench

- Memory-mapped 32-bit GPIO responder. It is the slave end of the CPU data-bus accesses that drive the system `io_gpio` pins.
- The CPU initiates register reads and writes. This block decodes them, drives or tristates each pin, and synchronises pin inputs.
- It also detects edges on inputs, latches them as sticky status and raises a level interrupt back toward the CPU.
- It sits beside the data RAM in the system address map.

---
 rtl/gpio_port_pkg.sv | 20 ++
 rtl/gpio_port_sync_edge.sv | 41 ++++
 rtl/gpio_port.sv | 113 +++++++++++
 tb/tb_gpio_port.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_port_pkg.sv
// Shared definitions for the GPIO responder: register indices and the
// base address the system decoder uses to route CPU accesses here.
package gpio_port_pkg;

   localparam int BUS_WIDTH = 32;

   // Word register indices as seen on the address bus
   localparam logic [2:0] GPIO_OUT  = 3'd0;
   localparam logic [2:0] GPIO_DIR  = 3'd1;
   localparam logic [2:0] GPIO_IN   = 3'd2;
   localparam logic [2:0] GPIO_STAT = 3'd3;
   localparam logic [2:0] GPIO_IEN  = 3'd4;
   localparam logic [2:0] GPIO_POL  = 3'd5;
   localparam logic [2:0] GPIO_SET  = 3'd6;
   localparam logic [2:0] GPIO_CLR  = 3'd7;

   // Base byte address of the GPIO window, next to the data RAM
   localparam logic [31:0] GPIO_BASE_ADDR = 32'h0001_0000;

endpackage

// File: rtl/gpio_port_sync_edge.sv
// Two-flop input synchroniser, one extra history flop, and a per-bit
// polarity-selected edge detector. Edges come only from sync2/sync3
// history, so changing pol never manufactures a flag by itself.
module gpio_sync_edge #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             clk_en,
   input  logic [WIDTH-1:0] pad,
   input  logic [WIDTH-1:0] pol,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] edge_hit
);

   logic [WIDTH-1:0] sync1_reg;
   logic [WIDTH-1:0] sync2_reg;
   logic [WIDTH-1:0] sync3_reg;

   // Shift pad samples through the synchroniser and history stage
   always_ff @(posedge clk) begin
      if (srst) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
         sync3_reg <= '0;
      end else if (clk_en) begin
         sync1_reg <= pad;
         sync2_reg <= sync1_reg;
         sync3_reg <= sync2_reg;
      end
   end

   assign level = sync2_reg;

   // pol = 1 selects rising edges, pol = 0 selects falling edges
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
      assign edge_hit[gi] = pol[gi] ? (sync2_reg[gi] & ~sync3_reg[gi])
                                    : (~sync2_reg[gi] & sync3_reg[gi]);
   end

endmodule

// File: rtl/gpio_port.sv
// Memory-mapped GPIO responder: register decode, pin drive/tristate,
// synchronised inputs, sticky edge status and a level interrupt.
module gpio_port
   import gpio_port_pkg::*;
#(
   parameter int          WIDTH     = 32,
   parameter logic [31:0] DIR_RESET = 32'h0,
   parameter logic [31:0] OUT_RESET = 32'h0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clk_en,
   input  logic             i_sel,
   input  logic             i_we,
   input  logic [2:0]       i_addr,
   input  logic [31:0]      i_wdata,
   output logic [31:0]      o_rdata,
   output logic             o_ack,
   output logic             o_irq,
   inout  wire  [WIDTH-1:0] io_gpio
);

   logic [WIDTH-1:0] out_reg;
   logic [WIDTH-1:0] dir_reg;
   logic [WIDTH-1:0] stat_reg;
   logic [WIDTH-1:0] ien_reg;
   logic [WIDTH-1:0] pol_reg;
   logic             ack_reg;
   logic             irq_reg;
   logic [BUS_WIDTH-1:0] rdata_reg;

   logic [BUS_WIDTH-1:0] rdata_next;
   logic [WIDTH-1:0]     stat_next;
   logic [WIDTH-1:0]     w1c_mask;
   logic [WIDTH-1:0]     wdata_w;
   logic [WIDTH-1:0]     pin_level;
   logic [WIDTH-1:0]     edge_hit;
   logic                 wr_accept;

   assign wdata_w   = i_wdata[WIDTH-1:0];
   assign wr_accept = i_sel & i_we & i_clk_en;

   gpio_sync_edge #(.WIDTH(WIDTH)) u_sync_edge (
      .clk      (i_clk),
      .srst     (i_rst),
      .clk_en   (i_clk_en),
      .pad      (io_gpio),
      .pol      (pol_reg),
      .level    (pin_level),
      .edge_hit (edge_hit)
   );

   // Each pin is driven from OUT only while its DIR bit selects output
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
      assign io_gpio[gi] = dir_reg[gi] ? out_reg[gi] : 1'bz;
   end

   // Read mux; bits above WIDTH and write-only registers read as zero
   always_comb begin
      rdata_next = '0;
      case (i_addr)
         GPIO_OUT:  rdata_next[WIDTH-1:0] = out_reg;
         GPIO_DIR:  rdata_next[WIDTH-1:0] = dir_reg;
         GPIO_IN:   rdata_next[WIDTH-1:0] = pin_level;
         GPIO_STAT: rdata_next[WIDTH-1:0] = stat_reg;
         GPIO_IEN:  rdata_next[WIDTH-1:0] = ien_reg;
         GPIO_POL:  rdata_next[WIDTH-1:0] = pol_reg;
         default:   rdata_next = '0;
      endcase
   end

   // Sticky status: a new edge beats a simultaneous write-one-to-clear
   always_comb begin
      w1c_mask  = (wr_accept && (i_addr == GPIO_STAT)) ? wdata_w : '0;
      stat_next = (stat_reg & ~w1c_mask) | edge_hit;
   end

   // Register file, bus response and interrupt, all held while disabled
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         out_reg   <= OUT_RESET[WIDTH-1:0];
         dir_reg   <= DIR_RESET[WIDTH-1:0];
         stat_reg  <= '0;
         ien_reg   <= '0;
         pol_reg   <= '0;
         ack_reg   <= 1'b0;
         rdata_reg <= '0;
         irq_reg   <= 1'b0;
      end else if (i_clk_en) begin
         ack_reg   <= i_sel;
         rdata_reg <= (i_sel && !i_we) ? rdata_next : '0;
         stat_reg  <= stat_next;
         irq_reg   <= |(stat_next & ien_reg);
         if (wr_accept) begin
            case (i_addr)
               GPIO_OUT: out_reg <= wdata_w;
               GPIO_DIR: dir_reg <= wdata_w;
               GPIO_IEN: ien_reg <= wdata_w;
               GPIO_POL: pol_reg <= wdata_w;
               GPIO_SET: out_reg <= out_reg | wdata_w;
               GPIO_CLR: out_reg <= out_reg & ~wdata_w;
               default: ;
            endcase
         end
      end
   end

   // A pending ack is only presented in an enabled cycle
   assign o_ack   = ack_reg & i_clk_en;
   assign o_rdata = o_ack ? rdata_reg : '0;
   assign o_irq   = irq_reg;

endmodule

// File: tb/tb_gpio_port.sv
// Self-checking bench for gpio_port: a vector table for register access,
// hand sequences for edge/interrupt timing, and an ack scoreboard.
module tb_gpio_port;
   import gpio_port_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clk_en = 1'b1;
   logic        sel = 1'b0;
   logic        we = 1'b0;
   logic [2:0]  addr = 3'd0;
   logic [31:0] wdata = 32'h0;
   wire  [31:0] rdata;
   wire         ack;
   wire         irq;
   wire  [31:0] gpio;

   // External pad drivers; pins 0..7 are released once the DUT drives them
   logic [31:0] ext_en  = 32'hFFFF_FFFF;
   logic [31:0] ext_val = 32'h5A5A_00C3;

   for (genvar gi = 0; gi < 32; gi++) begin : g_ext
      assign gpio[gi] = ext_en[gi] ? ext_val[gi] : 1'bz;
   end

   gpio_port #(.WIDTH(32), .DIR_RESET(32'h0), .OUT_RESET(32'h0)) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_clk_en (clk_en),
      .i_sel    (sel),
      .i_we     (we),
      .i_addr   (addr),
      .i_wdata  (wdata),
      .o_rdata  (rdata),
      .o_ack    (ack),
      .o_irq    (irq),
      .io_gpio  (gpio)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          is_read;
      logic [31:0] data;
      int          due;
      string       name;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Every ack must match the oldest expectation, in the expected cycle
   always @(negedge clk) begin
      if (ack === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
         end else begin
            mon_e = sb.pop_front();
            check({mon_e.name, "_ack_cycle"}, 32'(cyc), 32'(mon_e.due));
            if (mon_e.is_read)
               check(mon_e.name, rdata, mon_e.data);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One bus access accepted at the next edge; expectation queued on accept
   task automatic issue(input bit w, input logic [2:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input string name);
      exp_t e;
      sel = 1'b1; we = w; addr = a; wdata = d;
      @(posedge clk);
      #1;
      sel = 1'b0; we = 1'b0;
      if (clk_en && !rst) begin
         e.is_read = !w;
         e.data    = exp;
         e.due     = cyc;
         e.name    = name;
         sb.push_back(e);
      end
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while (sb.size() != 0 && k < 8) begin
         tick(1);
         k++;
      end
      check({name, "_drain"}, 32'(sb.size()), 32'd0);
   endtask

   typedef struct {
      bit          we;
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic [31:0] rexp;
      bit          pin_chk;
      logic [31:0] pin_exp;
      string       name;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit w, input logic [2:0] a, input logic [31:0] d,
                      input logic [31:0] rexp, input bit pc, input logic [31:0] pe,
                      input string name);
      vec_t v;
      v.we = w; v.addr = a; v.wdata = d; v.rexp = rexp;
      v.pin_chk = pc; v.pin_exp = pe; v.name = name;
      tbl.push_back(v);
   endtask

   initial begin
      add(1, GPIO_DIR,  32'h0000_00FF, 0, 0, 0, "w_dir");
      add(1, GPIO_OUT,  32'hA5A5_A5A5, 0, 0, 0, "w_out");
      add(0, GPIO_OUT,  0, 32'hA5A5_A5A5, 1, 32'h5A5A_00A5, "r_out");
      add(0, GPIO_DIR,  0, 32'h0000_00FF, 0, 0, "r_dir");
      add(1, GPIO_SET,  32'h0000_0100, 0, 0, 0, "w_set");
      add(1, GPIO_CLR,  32'h0000_0005, 0, 0, 0, "w_clr");
      add(0, GPIO_OUT,  0, 32'hA5A5_A5A0, 1, 32'h5A5A_00A0, "r_out_setclr");
      add(0, GPIO_SET,  0, 32'h0, 0, 0, "r_set_wo");
      add(0, GPIO_CLR,  0, 32'h0, 0, 0, "r_clr_wo");
      add(1, GPIO_IN,   32'hFFFF_FFFF, 0, 0, 0, "w_in_ignored");
      add(0, GPIO_OUT,  0, 32'hA5A5_A5A0, 0, 0, "r_out_after_in_wr");
      add(1, GPIO_IEN,  32'h0000_1000, 0, 0, 0, "w_ien");
      add(0, GPIO_IEN,  0, 32'h0000_1000, 0, 0, "r_ien");
      add(1, GPIO_POL,  32'h0000_1000, 0, 0, 0, "w_pol");
      add(0, GPIO_POL,  0, 32'h0000_1000, 0, 0, "r_pol");
      add(1, GPIO_STAT, 32'hFFFF_FFFF, 0, 0, 0, "w_stat_clear_all");
      add(0, GPIO_STAT, 0, 32'h0, 0, 0, "r_stat_clear");

      // Reset state
      tick(3);
      rst = 1'b0;
      check("reset_irq", {31'b0, irq}, 32'h0);
      check("reset_ack", {31'b0, ack}, 32'h0);
      issue(0, GPIO_OUT,  0, 32'h0, "rst_out");
      issue(0, GPIO_DIR,  0, 32'h0, "rst_dir");
      issue(0, GPIO_STAT, 0, 32'h0, "rst_stat");
      issue(0, GPIO_IEN,  0, 32'h0, "rst_ien");
      issue(0, GPIO_POL,  0, 32'h0, "rst_pol");
      drain("reset_reads");
      tick(2);
      // All pins externally driven: DUT must not be driving any of them
      issue(0, GPIO_IN, 0, 32'h5A5A_00C3, "in_all_undriven");
      drain("in_undriven");

      // Register table, issued back to back
      for (int i = 0; i < tbl.size(); i++) begin
         issue(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rexp, tbl[i].name);
         if (i == 0) ext_en = 32'hFFFF_FF00;
         if (tbl[i].pin_chk) check({tbl[i].name, "_pins"}, gpio, tbl[i].pin_exp);
      end
      drain("table");
      issue(0, GPIO_IN, 0, 32'h5A5A_00A0, "in_readback");

      // Rising edge on pin 12 with POL[12] = 1, IEN[12] = 1
      ext_val[12] = 1'b1;
      issue(0, GPIO_IN, 0, 32'h5A5A_00A0, "in_lat_e1");
      issue(0, GPIO_IN, 0, 32'h5A5A_00A0, "in_lat_e2");
      check("irq_before_edge", {31'b0, irq}, 32'h0);
      issue(0, GPIO_IN, 0, 32'h5A5A_10A0, "in_lat_e3");
      check("irq_rise", {31'b0, irq}, 32'h1);
      issue(0, GPIO_STAT, 0, 32'h0000_1000, "stat_rise_pol1");
      issue(1, GPIO_STAT, 32'h0000_1000, 0, "w1c_first");
      check("irq_fall_first", {31'b0, irq}, 32'h0);
      issue(0, GPIO_STAT, 0, 32'h0, "stat_after_w1c");

      // Falling edge with POL = 1 ignored; rising with POL = 0 ignored
      ext_val[12] = 1'b0;
      tick(5);
      issue(0, GPIO_STAT, 0, 32'h0, "fall_pol1_ignored");
      issue(1, GPIO_POL, 32'h0, 0, "w_pol0");
      ext_val[12] = 1'b1;
      tick(5);
      issue(0, GPIO_STAT, 0, 32'h0, "rise_pol0_ignored");
      check("irq_no_edge", {31'b0, irq}, 32'h0);
      ext_val[12] = 1'b0;
      tick(5);
      issue(0, GPIO_STAT, 0, 32'h0000_1000, "fall_pol0_flag");
      check("irq_fall_flag", {31'b0, irq}, 32'h1);

      // New edge detected in the same cycle as a clear: set wins
      ext_val[12] = 1'b1;
      tick(5);
      ext_val[12] = 1'b0;
      issue(0, GPIO_IN, 0, 32'h5A5A_10A0, "race_in_e1");
      issue(0, GPIO_STAT, 0, 32'h0000_1000, "race_stat_e2");
      issue(1, GPIO_STAT, 32'h0000_1000, 0, "race_w1c_e3");
      check("race_irq_held", {31'b0, irq}, 32'h1);
      issue(0, GPIO_STAT, 0, 32'h0000_1000, "race_stat_kept");
      issue(1, GPIO_STAT, 32'h0000_1000, 0, "quiet_w1c");
      check("quiet_irq_fall", {31'b0, irq}, 32'h0);
      issue(0, GPIO_STAT, 0, 32'h0, "quiet_stat_clear");
      drain("edges");

      // Clock enable low: no write, no ack
      clk_en = 1'b0;
      sel = 1'b1; we = 1'b1; addr = GPIO_OUT; wdata = 32'h0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("cen_no_ack", {31'b0, ack}, 32'h0);
      end
      sel = 1'b0; we = 1'b0;
      clk_en = 1'b1;
      tick(1);
      issue(0, GPIO_OUT, 0, 32'hA5A5_A5A0, "cen_out_unchanged");
      drain("cen");

      // Reset during an in-flight read drops the access
      issue(1, GPIO_POL, 32'h0000_1000, 0, "w_pol1_again");
      ext_val[12] = 1'b1;
      tick(5);
      check("pre_rst_irq", {31'b0, irq}, 32'h1);
      drain("pre_rst");
      rst = 1'b1;
      sel = 1'b1; we = 1'b0; addr = GPIO_OUT;
      @(posedge clk);
      #1;
      sel = 1'b0;
      rst = 1'b0;
      ext_en = 32'hFFFF_FFFF;
      check("rst_drop_ack", {31'b0, ack}, 32'h0);
      check("rst_irq_clear", {31'b0, irq}, 32'h0);
      issue(0, GPIO_OUT,  0, 32'h0, "rst2_out");
      issue(0, GPIO_DIR,  0, 32'h0, "rst2_dir");
      issue(0, GPIO_STAT, 0, 32'h0, "rst2_stat");
      issue(0, GPIO_IEN,  0, 32'h0, "rst2_ien");
      issue(0, GPIO_POL,  0, 32'h0, "rst2_pol");
      drain("rst2");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by %0t expected finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
